// File: rtl/branch_pred_pkg.sv
// Shared definitions for the branch predictor driver: FSM state encoding.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
package branch_pred_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_CAP  = 2'd2;
    localparam state_t ST_UPD  = 2'd3;

endpackage

// File: rtl/pred_fifo.sv
// DEPTH x 1-bit synchronous FIFO holding predictions of unresolved branches.
// Pointers wrap modulo DEPTH; push into a full FIFO or pop from an empty one is ignored.
module pred_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         din,
    input  logic                         pop,
    output logic                         dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage is not reset; an entry is only read after it has been written,
    // so clearing it would cost reset fanout for no behavioural gain.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor_driver.sv
// Requester-side sequencer for a 2-bit saturating branch predictor: requests a
// prediction per fetched branch, queues it, and applies resolutions in order.
// Define BRANCH_STATS_EN to add saturating br_count/miss_count statistics.
module branch_predictor_driver
    import branch_pred_pkg::*;
#(
    parameter int DEPTH = 4
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         br_valid,
    output logic                         br_ready,
    output logic                         pred_valid,
    output logic                         pred_taken,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         res_ready,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   inflight,
    output logic                         request,
    output logic                         result,
    output logic                         taken,
    input  logic                         prediction
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]             br_count,
    output logic [CNT_W-1:0]             miss_count
`endif
);

    state_t state;
    state_t state_nx;
    logic   idle;
    logic   res_acc;
    logic   br_acc;
    logic   fifo_full;
    logic   fifo_empty;
    logic   head;
    logic   miss;

    // Handshakes are only offered in IDLE and never while reset is asserted.
    assign idle      = (state == ST_IDLE) && rst_n;
    assign res_acc   = idle && res_valid && !fifo_empty;
    assign br_acc    = idle && br_valid && !res_acc && !fifo_full;
    assign res_ready = res_acc;
    assign br_ready  = br_acc;
    assign miss      = head ^ res_taken;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (state == ST_CAP),
        .din   (prediction),
        .pop   (res_acc),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (inflight)
    );

    // NOTE: state_nx gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (res_acc) begin
                    state_nx = ST_UPD;
                end else if (br_acc) begin
                    state_nx = ST_REQ;
                end
            end
            ST_REQ:  state_nx = ST_CAP;
            ST_CAP:  state_nx = ST_IDLE;
            ST_UPD:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Predictor-facing strobes are decoded from the next state so they line up
    // exactly with REQ/CAP and UPD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            request    <= 1'b0;
            result     <= 1'b0;
            taken      <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            state      <= state_nx;
            request    <= (state_nx == ST_REQ) || (state_nx == ST_CAP);
            result     <= (state_nx == ST_UPD);
            taken      <= res_acc && res_taken;
            pred_valid <= (state == ST_CAP);
            if (state == ST_CAP) begin
                pred_taken <= prediction;
            end
            mispredict <= res_acc && miss;
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (res_acc && (br_count != CNT_MAX)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (res_acc && miss && (miss_count != CNT_MAX)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor_driver.sv
// Self-checking bench for branch_predictor_driver: directed scenarios plus random
// traffic, scored by a transaction-level model and a behavioural 2-bit predictor.
module tb_branch_predictor_driver;

    localparam int DEPTH   = 4;
    localparam int IW      = $clog2(DEPTH + 1);
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          br_valid;
    logic          br_ready;
    logic          pred_valid;
    logic          pred_taken;
    logic          res_valid;
    logic          res_taken;
    logic          res_ready;
    logic          mispredict;
    logic [IW-1:0] inflight;
    logic          request;
    logic          result;
    logic          taken;
    logic          prediction = 1'b0;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    branch_predictor_driver #(
        .DEPTH (DEPTH)
`ifdef BRANCH_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_ready  (res_ready),
        .mispredict (mispredict),
        .inflight   (inflight),
        .request    (request),
        .result     (result),
        .taken      (taken),
        .prediction (prediction)
`ifdef BRANCH_STATS_EN
        ,
        .br_count   (br_count),
        .miss_count (miss_count)
`endif
    );

    // Behavioural 2-bit saturating predictor; it has no reset and starts at 00.
    logic [1:0] pctr = 2'b00;
    always @(posedge clk) begin
        if (request) prediction <= pctr[1];
        if (result) begin
            if (taken) pctr <= (pctr == 2'd3) ? 2'd3 : pctr + 2'd1;
            else       pctr <= (pctr == 2'd0) ? 2'd0 : pctr - 2'd1;
        end
    end

    // Transaction-level model of the driver.
    logic q[$];
    int   br_cd = 0;
    int   res_cd = 0;
    logic pred_exp = 1'b0;
    logic mis_exp = 1'b0;
    logic tk_exp = 1'b0;
    int   n_res = 0;
    int   n_mis = 0;
    int   br_acc_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        br_cd  = 0;
        res_cd = 0;
        n_res  = 0;
        n_mis  = 0;
    endtask

    // One clock: drive inputs, check handshakes, advance, check registered outputs.
    task automatic tick(input logic bv, input logic rv, input logic rt);
        logic idle_m, exp_rr, exp_br, exp_pv, exp_upd;
        br_valid  = bv;
        res_valid = rv;
        res_taken = rt;
        #1;
        idle_m = (br_cd == 0) && (res_cd == 0);
        exp_rr = idle_m && rv && (q.size() != 0);
        exp_br = idle_m && bv && !exp_rr && (q.size() < DEPTH);
        check("res_ready", res_ready, exp_rr);
        check("br_ready", br_ready, exp_br);
        if (exp_rr) begin
            mis_exp = q.pop_front() ^ rt;
            tk_exp  = rt;
            res_cd  = 2;
            if (n_res < CNT_MAX) n_res++;
            if (mis_exp && n_mis < CNT_MAX) n_mis++;
        end
        if (exp_br) begin
            pred_exp = pctr[1];
            br_cd    = 3;
            br_acc_cnt++;
        end
        @(posedge clk);
        #1;
        exp_pv = (br_cd == 1);
        if (br_cd != 0) br_cd--;
        exp_upd = (res_cd == 2);
        if (res_cd != 0) res_cd--;
        if (exp_pv) q.push_back(pred_exp);
        check("pred_valid", pred_valid, exp_pv);
        if (exp_pv) check("pred_taken", pred_taken, pred_exp);
        check("request", request, br_cd != 0);
        check("result", result, exp_upd);
        if (exp_upd) check("taken", taken, tk_exp);
        check("mispredict", mispredict, exp_upd && mis_exp);
        check("inflight", inflight, q.size());
        check("req_res_overlap", request && result, 1'b0);
`ifdef BRANCH_STATS_EN
        check("br_count", br_count, n_res);
        check("miss_count", miss_count, n_mis);
`endif
    endtask

    task automatic settle();
        for (int i = 0; i < 8 && (br_cd != 0 || res_cd != 0); i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        br_valid  = 1'b1;
        res_valid = 1'b1;
        res_taken = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state: every output low even with both requesters active.
        check("rst_br_ready", br_ready, 1'b0);
        check("rst_res_ready", res_ready, 1'b0);
        check("rst_pred_valid", pred_valid, 1'b0);
        check("rst_pred_taken", pred_taken, 1'b0);
        check("rst_mispredict", mispredict, 1'b0);
        check("rst_inflight", inflight, 0);
        check("rst_request", request, 1'b0);
        check("rst_result", result, 1'b0);
        check("rst_taken", taken, 1'b0);
        rst_n = 1'b1;

        // 1) one branch with the predictor at 00.
        tick(1'b1, 1'b0, 1'b0);
        settle();
        check("t1_inflight", inflight, 1);
        check("t1_pred_taken", pred_taken, 1'b0);

        // 2) second branch, two taken resolutions, then a branch predicted taken.
        tick(1'b1, 1'b0, 1'b0);
        settle();
        tick(1'b0, 1'b1, 1'b1);
        settle();
        tick(1'b0, 1'b1, 1'b1);
        settle();
        tick(1'b1, 1'b0, 1'b0);
        settle();
        check("t2_pred_taken", pred_taken, 1'b1);

        // 3) fill the FIFO, hold br_valid, free one slot.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            settle();
        end
        check("t3_full", inflight, DEPTH);
        br_acc_cnt = 0;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0);
        check("t3_blocked", br_acc_cnt, 0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
        settle();
        check("t3_fifth", br_acc_cnt, 1);
        check("t3_refull", inflight, DEPTH);

        // 4) drain, then resolutions against an empty FIFO stall.
        for (int i = 0; i < 16 && q.size() != 0; i++) begin
            tick(1'b0, 1'b1, 1'b0);
            settle();
        end
        check("t4_empty", inflight, 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1);

        // 5) branch and resolution together: resolution first, then the branch.
        tick(1'b1, 1'b0, 1'b0);
        settle();
        br_acc_cnt = 0;
        tick(1'b1, 1'b1, 1'b1);
        check("t5_res_first", br_acc_cnt, 0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
        check("t5_br_after", br_acc_cnt, 1);
        settle();

        // 6) reset while in CAP.
        tick(1'b1, 1'b0, 1'b0);
        settle();
        tick(1'b0, 1'b1, 1'b0);
        settle();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("t6_in_cap", request, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_request", request, 1'b0);
        check("t6_inflight", inflight, 0);
        check("t6_pred_valid", pred_valid, 1'b0);
`ifdef BRANCH_STATS_EN
        check("t6_br_count", br_count, 0);
        check("t6_miss_count", miss_count, 0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Five forced mispredicts saturate a 2-bit miss counter at 3.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            settle();
            tick(1'b0, 1'b1, ~q[0]);
            settle();
        end
`ifdef BRANCH_STATS_EN
        check("t6_miss_sat", miss_count, 3);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), 1'(($urandom % 3) != 0), 1'($urandom_range(0, 1)));
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
